// File: rtl/pwm_sample_ctrl.sv
// pwm_sample_ctrl: PCM-to-PWM sequencer. Owns the PWM period counter, a small
// sample FIFO on a valid/ready input, boundary-only threshold loads, soft
// ramping on enable/disable, and underrun reporting.
module pwm_sample_ctrl #(
  parameter int unsigned STEP  = 64,       // counter increment, power of two, 1..32768
  parameter int unsigned DEPTH = 4,        // FIFO entries, power of two, >= 2
  parameter logic [15:0] RAMP  = 16'h0800  // threshold change per boundary while ramping
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mute,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [15:0]                  s_data,
  output logic                         pwm_out,
  output logic                         period_start,
  output logic                         underrun,
  output logic [7:0]                   underrun_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned LW       = $clog2(DEPTH + 1);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [15:0] STEP_INC = 16'(STEP);
  localparam logic [15:0] LAST_CNT = 16'(32'd65536 - 32'(STEP));
  localparam logic [15:0] MID      = 16'h8000;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   thr_q, thr_d;
  logic          pwm_q, pwm_d;
  logic          underrun_q, underrun_d;
  logic [7:0]    ur_cnt_q, ur_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0]   mem [DEPTH];

  logic        is_idle;
  logic        boundary;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        flush;
  logic [15:0] head;
  logic [16:0] ramp_sum;

  assign is_idle  = (state_q == ST_IDLE);
  // The boundary cycle is the last cycle of a period; its closing edge wraps cnt to 0.
  assign boundary = !is_idle && (cnt_q == LAST_CNT);
  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign s_ready  = !full && !is_idle;
  assign push     = s_valid && s_ready;
  // Emptiness is judged on the registered level, so a push landing on the
  // boundary cycle is stored but not seen by that boundary.
  assign pop      = boundary && (state_q == ST_RUN) && !empty;
  assign head     = mem[rd_ptr_q];

  assign pwm_out      = pwm_q;
  assign period_start = !is_idle && (cnt_q == 16'h0000);
  assign underrun     = underrun_q;
  assign underrun_cnt = ur_cnt_q;
  assign fifo_level   = level_q;

  // Sequencer: period counter, threshold updates at boundaries, state changes, underrun.
  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    flush      = 1'b0;
    underrun_d = 1'b0;
    ur_cnt_d   = ur_cnt_q;
    ramp_sum   = {1'b0, thr_q} + {1'b0, RAMP};
    cnt_d      = is_idle ? 16'h0000 : cnt_q + STEP_INC;
    pwm_d      = !is_idle && (cnt_q < thr_q);

    case (state_q)
      ST_IDLE: begin
        thr_d = 16'h0000;
        if (en) state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP: begin
        if (!en) begin
          state_d = ST_RAMP_DOWN;
        end else if (boundary) begin
          if (thr_q >= MID) begin
            thr_d   = MID;
            state_d = ST_RUN;
          end else begin
            // 17-bit sum so a large RAMP cannot wrap past midscale.
            thr_d = (ramp_sum > {1'b0, MID}) ? MID : ramp_sum[15:0];
          end
        end
      end
      ST_RUN: begin
        if (boundary) begin
          if (!empty) begin
            thr_d = mute ? MID : (head ^ MID);
          end else begin
            underrun_d = 1'b1;
            if (ur_cnt_q != 8'hFF) ur_cnt_d = ur_cnt_q + 8'd1;
          end
        end
        if (!en) state_d = ST_RAMP_DOWN;
      end
      ST_RAMP_DOWN: begin
        if (en) begin
          state_d = ST_RAMP_UP;
        end else if (boundary) begin
          if (thr_q == 16'h0000) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
          end else begin
            thr_d = (thr_q > RAMP) ? (thr_q - RAMP) : 16'h0000;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        thr_d   = 16'h0000;
        flush   = 1'b1;
      end
    endcase
  end

  // FIFO bookkeeping: pointer advance, occupancy, flush on entry to idle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // State registers; reset clears everything immediately, even mid-period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'h0000;
      thr_q      <= 16'h0000;
      pwm_q      <= 1'b0;
      underrun_q <= 1'b0;
      ur_cnt_q   <= 8'h00;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      thr_q      <= thr_d;
      pwm_q      <= pwm_d;
      underrun_q <= underrun_d;
      ur_cnt_q   <= ur_cnt_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Sample storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_pwm_sample_ctrl.sv
// tb_pwm_sample_ctrl: directed bench for pwm_sample_ctrl. STEP is raised to
// 1024 (64-cycle periods) so the long underrun-saturation sequence stays short;
// high-time expectations scale accordingly (50% = 32 cycles, 100% = 64).
module tb_pwm_sample_ctrl;

  localparam int unsigned STEP = 1024;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] RAMP = 16'h0800;
  localparam int PER = 65536 / STEP;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mute;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        pwm_out;
  logic        period_start;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  pwm_sample_ctrl #(.STEP(STEP), .DEPTH(DEPTH), .RAMP(RAMP)) dut (
    .clk(clk), .rst(rst), .en(en), .mute(mute),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .pwm_out(pwm_out), .period_start(period_start), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle with period_start high, bounded to two periods.
  task automatic wait_ps(input string tag);
    for (int i = 0; i < 2 * PER; i++) begin
      tick();
      if (period_start) break;
    end
    chk(tag, period_start, 1);
  endtask

  // From cycle 0 of a period, sample the PER following cycles (cycle 1 .. next cycle 0).
  // s_valid is dropped after the first edge so a single push can precede a measurement.
  task automatic period(input string tag, input int exp_hi, input int exp_ps, input int exp_ur);
    int hi, ps, ur;
    hi = 0; ps = 0; ur = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (i == 0) s_valid = 1'b0;
      hi += int'(pwm_out);
      ps += int'(period_start);
      ur += int'(underrun);
    end
    chk({tag, "_high"}, hi, exp_hi);
    chk({tag, "_pstart"}, ps, exp_ps);
    chk({tag, "_underrun"}, ur, exp_ur);
  endtask

  task automatic push(input logic [15:0] d);
    chk("push_ready", s_ready, 1);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] bp [5];
    int th;
    int ur_sum;
    bp[0] = 16'h8000; bp[1] = 16'h0000; bp[2] = 16'hC000; bp[3] = 16'h4000; bp[4] = 16'h7FFF;

    // Reset held with en and s_valid active.
    rst = 1'b0; en = 1'b1; mute = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
    repeat (3) tick();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_pstart", period_start, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ucnt", underrun_cnt, 0);
    chk("rst_level", fifo_level, 0);

    // Release into IDLE with en low.
    en = 1'b0; s_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("idle_ready", s_ready, 0);
    chk("idle_pwm", pwm_out, 0);
    chk("idle_pstart", period_start, 0);

    // Soft start: thr climbs 0x800 per boundary, 17 boundaries to RUN.
    en = 1'b1;
    tick();
    chk("start_pstart", period_start, 1);
    for (int k = 1; k <= 17; k++) begin
      period($sformatf("ramp%0d", k), ((k - 1) * 2 > 32) ? 32 : (k - 1) * 2, 1, 0);
    end
    // First RUN period: midscale, empty FIFO at its boundary.
    period("run18", 32, 1, 1);
    chk("ucnt_first", underrun_cnt, 1);
    period("run19_hold", 32, 1, 1);
    chk("ucnt_second", underrun_cnt, 2);

    // Duty mapping: -32768, 0, 32767.
    push(16'h8000);
    push(16'h0000);
    push(16'h7FFF);
    chk("level_three", fifo_level, 3);
    wait_ps("wait_map");
    chk("map_level", fifo_level, 2);
    chk("map_no_underrun", underrun, 0);
    period("map_min", 0, 1, 0);
    period("map_mid", 32, 1, 0);
    period("map_max", 64, 1, 1);
    chk("ucnt_third", underrun_cnt, 3);

    // Mute forces midscale for a full-scale sample.
    mute = 1'b1;
    push(16'h7FFF);
    wait_ps("wait_mute");
    mute = 1'b0;
    period("mute", 32, 1, 1);
    chk("ucnt_fourth", underrun_cnt, 4);

    // 300 consecutive empty boundaries saturate the counter.
    ur_sum = 0;
    for (int i = 0; i < 300 * PER; i++) begin
      tick();
      ur_sum += int'(underrun);
    end
    chk("sat_pulses", ur_sum, 300);
    chk("sat_ucnt", underrun_cnt, 255);

    // Backpressure: five back-to-back pushes, the fifth held.
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data  = bp[i];
      tick();
    end
    s_data = bp[4];
    chk("bp_full_ready", s_ready, 0);
    chk("bp_full_level", fifo_level, 4);
    wait_ps("wait_bp");
    chk("bp_pop_level", fifo_level, 3);
    chk("bp_reready", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("bp_fifth_level", fifo_level, 4);
    chk("bp_fifth_ready", s_ready, 0);
    wait_ps("wait_bp_order");
    period("bp_d1", 32, 1, 0);
    period("bp_d2", 16, 1, 0);
    period("bp_d3", 48, 1, 0);
    period("bp_d4", 64, 1, 1);
    chk("bp_ucnt", underrun_cnt, 255);

    // Shutdown from full scale, with one push landing as en drops.
    en = 1'b0;
    s_valid = 1'b1;
    s_data = 16'h1234;
    th = 16'hFFFF;
    for (int k = 0; k < 40; k++) begin
      period($sformatf("down%0d", k), (th + int'(STEP) - 1) / int'(STEP), (th == 0) ? 0 : 1, 0);
      if (k == 0) chk("down_level", fifo_level, 1);
      if (th == 0) break;
      th = (th > int'(RAMP)) ? th - int'(RAMP) : 0;
    end
    chk("off_ready", s_ready, 0);
    chk("off_level", fifo_level, 0);
    chk("off_pwm", pwm_out, 0);
    repeat (3) tick();
    chk("off_pstart", period_start, 0);
    chk("off_pwm_later", pwm_out, 0);

    // Resume mid-ramp: up to 0x2000, down to 0x1000, back up from there.
    en = 1'b1;
    tick();
    chk("resume_pstart", period_start, 1);
    period("up1", 0, 1, 0);
    period("up2", 2, 1, 0);
    period("up3", 4, 1, 0);
    period("up4", 6, 1, 0);
    en = 1'b0;
    period("dn5", 8, 1, 0);
    period("dn6", 6, 1, 0);
    en = 1'b1;
    period("re7", 4, 1, 0);
    period("re8", 6, 1, 0);
    period("re9", 8, 1, 0);

    // Asynchronous reset mid-period.
    push(16'h0000);
    repeat (3) tick();
    chk("pre_rst_pwm", pwm_out, 1);
    chk("pre_rst_level", fifo_level, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_pwm", pwm_out, 0);
    chk("arst_ready", s_ready, 0);
    chk("arst_pstart", period_start, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_ucnt", underrun_cnt, 0);
    chk("arst_level", fifo_level, 0);
    en = 1'b0;
    tick();
    rst = 1'b1;
    repeat (2) tick();
    chk("post_rst_ready", s_ready, 0);
    chk("post_rst_pwm", pwm_out, 0);
    chk("post_rst_pstart", period_start, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_sample_ctrl.md
# pwm_sample_ctrl

Sequencer for the PCM-to-PWM output path. It owns the PWM period counter and a small sample FIFO fed by the FM core through a valid/ready handshake. It loads a new duty threshold only at period boundaries, so no glitches occur mid-period. It also soft-ramps the duty cycle on enable and disable to avoid audible pops, and reports FIFO underruns.

## Interface
- STEP, 64: counter increment per clock. Must be a power of two, 1..32768. Period = 65536/STEP cycles.
- DEPTH, 4: sample FIFO entries. Must be a power of two, ≥2.
- RAMP, 16'h0800: threshold change applied per period boundary while ramping.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  level; 1 = run output, 0 = ramp down to idle
- mute  in  1  level; in RUN, boundary loads midscale (16'h8000) instead of the sample; FIFO still pops
- s_valid  in  1  sample valid
- s_ready  out  1  sample accepted when s_valid && s_ready
- s_data  in  16  signed PCM sample
- pwm_out  out  1  registered PWM output
- period_start  out  1  high during the first cycle of each period (cnt==0) when not IDLE
- underrun  out  1  one-cycle pulse: RUN boundary found FIFO empty
- underrun_cnt  out  8  saturating underrun count (max 255); cleared only by rst
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- cnt is a 16-bit unsigned counter. It advances by STEP each cycle in every state except IDLE and wraps modulo 2^16.
- The boundary cycle is the cycle with cnt == 16'h10000-STEP. On the edge ending that cycle, cnt→0 and thr/state update.
- thr is a 16-bit unsigned threshold.
- pwm_out is registered from the previous cycle: pwm_out(k+1) = (cnt(k) < thr(k)), unsigned compare. In IDLE, pwm_out(k+1)=0.
- Sample mapping: thr = s_data ^ 16'h8000. So -32768→0 (never high), 0→16'h8000 (50%), 32767→16'hFFFF.
- FIFO: s_ready = !full && state != IDLE.
  - A push while full is blocked even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle when not full keep the level unchanged.
  - A push into an empty FIFO on a boundary cycle is stored, but the boundary still sees empty.
- States:
  - IDLE: cnt=0, thr=0, FIFO empty. en=1 → RAMP_UP on the next edge; cnt starts from 0.
  - RAMP_UP: at each boundary, thr = min(thr+RAMP, 16'h8000), saturating with no 16-bit wrap. If thr was already ≥16'h8000 at the boundary, set thr=16'h8000 and go → RUN. en=0 → RAMP_DOWN immediately, no boundary wait. No pops.
  - RUN: at each boundary:
    - FIFO nonempty: pop; thr = mute ? 16'h8000 : popped^16'h8000.
    - FIFO empty: thr holds its value; pulse underrun; underrun_cnt+1, saturating.
    - en=0 → RAMP_DOWN on the next edge, with no pop after that edge.
  - RAMP_DOWN: at each boundary, thr = (thr > RAMP) ? thr-RAMP : 0. If thr was 0 at the boundary → IDLE and flush the FIFO. en=1 → RAMP_UP, continuing from the current thr. FIFO accepts pushes but never pops.
- rst low: immediately sets state=IDLE and clears cnt, thr, FIFO, underrun_cnt and all outputs, including mid-period.

## Timing
- Reset values: pwm_out=0, s_ready=0, period_start=0, underrun=0, underrun_cnt=0, fifo_level=0.
- Handshake-to-threshold latency: at least one full period; a sample takes effect at the first boundary where it is the FIFO head.
- pwm_out reflects a new thr starting in cycle 1 of the new period (the cycle after cnt==0), because of its one-cycle register lag.
- s_ready deasserts on the edge that stores the DEPTH-th entry. It reasserts the cycle after the pop.
- underrun is high in the cycle cnt==0 that follows the offending boundary.
- fifo_level updates on the same edge as the push or pop.

## Test plan
- Reset: hold rst=0 with en=1 and s_valid=1 → all outputs 0 and s_ready=0. Release → IDLE, outputs stay 0.
- Soft start (STEP=64, RAMP=16'h0800): assert en → RUN after 17 boundaries.
  - Period 16 ends with thr=16'h8000.
  - pwm_out is high for exactly 512 of the 1024 cycles of each RUN period that has no new samples.
- Duty mapping in RUN: push -32768, 0, 32767 → three consecutive periods with high time 0, 512, 1024 cycles.
  - period_start pulses exactly every 1024 cycles.
  - mute=1 during the third push → 512 cycles instead.
- Underrun: FIFO empty at a RUN boundary → underrun pulses 1 cycle, thr is unchanged, underrun_cnt=1.
  - 300 consecutive empty boundaries → underrun_cnt saturates at 255.
- Backpressure: push 5 samples back-to-back in the same period → 4 accepted, s_ready=0 with the 5th held stable.
  - At the next boundary, fifo_level 4→3, s_ready=1 on the next cycle, and the 5th is accepted.
- Shutdown and reset:
  - With thr=16'hFFFF in RUN, drop en → thr decrements 16'h0800 per boundary to 0, then IDLE with FIFO flushed and pwm_out=0.
  - Re-asserting en mid-ramp resumes RAMP_UP from the current thr.
  - Pulsing rst low mid-period → outputs 0 immediately.
